// File: rtl/ibuf2axis.sv
// ibuf2axis: drains header+data packet records from the ibuf onto a 64-bit AXI4-Stream.
// Define IBUF2AXIS_STATS_EN to add the pkt_count/drop_count outputs.
module ibuf2axis #(
   parameter int unsigned BW       = 10,
   parameter logic [7:0]  SRC_PORT = 8'h00,
   parameter logic [15:0] MAX_LEN  = 16'd1518
) (
   input  logic          m_axis_aclk,
   input  logic          m_axis_aresetp,
   input  logic [BW:0]   committed_prod,
   output logic [BW:0]   committed_cons,
   output logic [BW-1:0] rd_addr,
   input  logic [63:0]   rd_data,
   output logic [63:0]   m_axis_tdata,
   output logic [7:0]    m_axis_tstrb,
   output logic [127:0]  m_axis_tuser,
   output logic          m_axis_tvalid,
   output logic          m_axis_tlast,
   input  logic          m_axis_tready
`ifdef IBUF2AXIS_STATS_EN
   ,
   output logic [31:0]   pkt_count,
   output logic [31:0]   drop_count
`endif
);

   localparam int unsigned CW = (BW + 1 > 14) ? BW + 1 : 14;

   typedef enum logic [2:0] {StIdle, StHdrRd, StHdrChk, StData, StDrop} state_e;

   state_e             state_q, state_d;
   logic [BW:0]        prod_q, rd_ptr_q, rd_ptr_d, cons_q, cons_d, avail;
   logic [13:0]        words_q, words_d, issued_q, issued_d, sent_q, sent_d, hdr_words;
   logic [2:0]         len_lo_q, len_lo_d;
   logic [127:0]       tuser_q, tuser_d;
   logic [15:0]        hdr_len;
   logic [16:0]        hdr_len_p7;
   logic [1:0][63:0]   skid_q;
   logic [1:0]         cnt_q, cnt_d;
   logic [2:0]         occ;
   logic [7:0]         last_strb;
   logic               wr_idx_q, rd_idx_q, inflight_q;
   logic               hdr_bad, drop_ok, last_beat, fire, issue;

   assign avail      = prod_q - rd_ptr_q;
   assign rd_addr    = rd_ptr_q[BW-1:0];
   assign committed_cons = cons_q;
   assign hdr_len    = rd_data[47:32];
   assign hdr_len_p7 = {1'b0, hdr_len} + 17'd7;
   assign hdr_words  = hdr_len_p7[16:3];
   assign hdr_bad    = (hdr_len == 16'd0) || (hdr_len > MAX_LEN);
   assign drop_ok    = CW'(avail) >= CW'(words_q);
   assign last_beat  = (sent_q == words_q - 14'd1);
   assign fire       = m_axis_tvalid && m_axis_tready;
   // Occupancy after this cycle's pop; keeps buffered + in-flight words at most 2.
   assign occ        = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, fire};
   assign issue      = (state_q == StData) && (avail != '0) && (issued_q < words_q)
                       && (occ < 3'd2);
   assign cnt_d      = cnt_q + {1'b0, inflight_q} - {1'b0, fire};
   assign last_strb  = (len_lo_q == 3'd0) ? 8'hFF : (8'h01 << len_lo_q) - 8'h01;

   always_ff @(posedge m_axis_aclk or posedge m_axis_aresetp) begin
      if (m_axis_aresetp) state_q <= StIdle;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (avail != '0) state_d = StHdrRd;
         StHdrRd:  state_d = StHdrChk;
         StHdrChk: state_d = hdr_bad ? StDrop : StData;
         StData:   if (fire && last_beat) state_d = StIdle;
         StDrop:   if (drop_ok) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      cons_d   = cons_q;
      words_d  = words_q;
      issued_d = issued_q;
      sent_d   = sent_q;
      len_lo_d = len_lo_q;
      tuser_d  = tuser_q;
      if (state_q == StHdrChk) begin
         rd_ptr_d = rd_ptr_q + (BW + 1)'(1);
         cons_d   = rd_ptr_q + (BW + 1)'(1);
         words_d  = hdr_words;
         issued_d = 14'd0;
         sent_d   = 14'd0;
         len_lo_d = hdr_len[2:0];
         tuser_d  = {104'd0, SRC_PORT, hdr_len};
      end
      if (issue) begin
         rd_ptr_d = rd_ptr_q + (BW + 1)'(1);
         issued_d = issued_q + 14'd1;
      end
      if (fire) begin
         cons_d = cons_q + (BW + 1)'(1);
         sent_d = sent_q + 14'd1;
      end
      if (state_q == StDrop && drop_ok) begin
         rd_ptr_d = rd_ptr_q + (BW + 1)'(words_q);
         cons_d   = cons_q + (BW + 1)'(words_q);
      end
   end

   always_ff @(posedge m_axis_aclk or posedge m_axis_aresetp) begin
      if (m_axis_aresetp) begin
         prod_q     <= '0;
         rd_ptr_q   <= '0;
         cons_q     <= '0;
         words_q    <= '0;
         issued_q   <= '0;
         sent_q     <= '0;
         len_lo_q   <= '0;
         tuser_q    <= '0;
         skid_q     <= '0;
         cnt_q      <= '0;
         wr_idx_q   <= 1'b0;
         rd_idx_q   <= 1'b0;
         inflight_q <= 1'b0;
      end else begin
         prod_q     <= committed_prod;
         rd_ptr_q   <= rd_ptr_d;
         cons_q     <= cons_d;
         words_q    <= words_d;
         issued_q   <= issued_d;
         sent_q     <= sent_d;
         len_lo_q   <= len_lo_d;
         tuser_q    <= tuser_d;
         cnt_q      <= cnt_d;
         inflight_q <= issue;
         if (inflight_q) begin
            skid_q[wr_idx_q] <= rd_data;
            wr_idx_q         <= ~wr_idx_q;
         end
         if (fire) rd_idx_q <= ~rd_idx_q;
      end
   end

   always_comb begin
      m_axis_tvalid = (cnt_q != 2'd0);
      m_axis_tdata  = skid_q[rd_idx_q];
      m_axis_tuser  = tuser_q;
      m_axis_tlast  = m_axis_tvalid && last_beat;
      m_axis_tstrb  = 8'h00;
      if (m_axis_tvalid) m_axis_tstrb = last_beat ? last_strb : 8'hFF;
   end

`ifdef IBUF2AXIS_STATS_EN
   always_ff @(posedge m_axis_aclk or posedge m_axis_aresetp) begin
      if (m_axis_aresetp) begin
         pkt_count  <= '0;
         drop_count <= '0;
      end else begin
         if (fire && last_beat) pkt_count <= pkt_count + 32'd1;
         if (state_q == StHdrChk && hdr_bad) drop_count <= drop_count + 32'd1;
      end
   end
`endif

endmodule

// File: doc/ibuf2axis.md
Name: ibuf2axis

Overview:
- Consumer side of the ibuf written by the AXI4-Stream ingress writer.
- Reads packet records (header word + data words) from the dual-port ibuf and re-emits each packet as 64-bit AXI4-Stream toward the TX MAC path.
- Returns consumed space to the writer through committed_cons.

Parameters:
- BW, 10: ibuf address width; ibuf depth is 2**BW words.
- SRC_PORT, 8'h00: value driven on m_axis_tuser[23:16].
- MAX_LEN, 16'd1518: largest legal packet length in bytes.

Ports:
- m_axis_aclk  in  1  clock.
- m_axis_aresetp  in  1  asynchronous active-high reset.
- committed_prod  in  BW+1  writer pointer; words below it are written.
- committed_cons  out  BW+1  reader pointer; words below it may be overwritten.
- rd_addr  out  BW  ibuf read address; read data valid 1 cycle later.
- rd_data  in  64  ibuf read data.
- m_axis_tdata  out  64  stream data.
- m_axis_tstrb  out  8  byte strobes; all ones except on the last beat.
- m_axis_tuser  out  128  [15:0]=length in bytes, [23:16]=SRC_PORT, remaining bits 0.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tlast  out  1  last beat of the packet.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset: tvalid, tlast, tdata, tstrb, tuser, rd_addr and committed_cons are all 0. Internal rd_ptr (BW+1 bits) is 0 and the FSM is in IDLE. Reset mid-packet abandons the packet with no tlast.
- Pointer capture: committed_prod is registered once (prod_q) before use, covering the writer's registered-write latency.
- avail = prod_q - rd_ptr, computed modulo 2**(BW+1). Empty when avail==0. rd_addr = rd_ptr[BW-1:0]; wrap is implicit.
- Record format:
  - Header word: [47:32]=len, all other bits ignored.
  - Followed by words = (len+7)>>3 data words, little-endian bytes.
- FSM states:
  - IDLE: if avail>=1, present rd_ptr and go to HDR_RD.
  - HDR_RD: wait the 1-cycle read latency; go to HDR_CHK.
  - HDR_CHK: latch len and words; rd_ptr+=1; committed_cons<=rd_ptr+1.
    - If len==0 or len>MAX_LEN, go to DROP.
    - Otherwise go to DATA.
  - DATA: stream data words through a 2-entry output skid buffer.
    - Issue a read only when avail>0, words_issued<words, and (skid occupancy + reads in flight)<2.
    - Each read increments rd_ptr.
    - Each accepted beat (tvalid&&tready) increments committed_cons by 1.
    - The last beat asserts tlast and tstrb = (len[2:0]==0) ? 8'hFF : (8'h01<<len[2:0])-1.
    - tuser is constant for the whole packet.
    - After the tlast handshake go to IDLE.
  - DROP: wait until avail>=words, then rd_ptr+=words, committed_cons+=words, go to IDLE. Nothing is emitted.
- Handshake: AXIS rules apply. Once tvalid is asserted, tdata/tstrb/tuser/tlast hold until tready. tvalid drops only after the handshake and only if the skid buffer is empty.
- Throughput: 1 beat/cycle sustained while avail>0 and tready=1. Header overhead is 3 cycles per packet.
- Stalls:
  - ibuf empty mid-packet: tvalid deasserts between beats and no bogus data is emitted.
  - tready low: reads stop, with at most 2 words buffered.
- committed_cons never exceeds prod_q. At equality (avail==0) no read is issued.

Optional Feature:
- Macro IBUF2AXIS_STATS_EN.
- When defined, adds outputs pkt_count[31:0] and drop_count[31:0]:
  - pkt_count increments on each tlast handshake.
  - drop_count increments on entry to DROP.
  - Both reset to 0, wrap at 2**32, and do not saturate.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Single packet: header len=64 + 8 words at addr 0, prod=9, tready=1 -> 8 beats, tstrb=FF on all, tlast on beat 8, tuser[15:0]=64, tuser[23:16]=SRC_PORT, committed_cons ends at 9.
- Odd length: len=61 (8 words) -> last beat tstrb=8'h1F, tlast=1; len=1 -> single beat, tstrb=8'h01.
- Backpressure: tready toggling 1/0 every cycle on a 20-word packet -> no lost or duplicated beat, tdata stable while stalled, committed_cons advances only on handshakes.
- Partial availability plus wrap: BW=4, packet starting at rd_ptr=14, prod increased one word every 5 cycles -> tvalid gaps with correct data order across address 15->0, and committed_cons never exceeds prod.
- Drop: len=0, then len=2000 with 250 words, then valid len=64 -> only the 64-byte packet is emitted, committed_cons skips 1 and 251 words, drop_count=2 when IBUF2AXIS_STATS_EN is defined.
- Reset mid-packet: assert m_axis_aresetp during beat 3 -> tvalid=0 and committed_cons=0 immediately, then a clean restart from address 0.
